// File: rtl/hr_dpwm_multiphase.sv
// Multi-channel phase-shifted high-resolution DPWM with dead-time and double-buffered config.
// Outputs registered, 1 clk latency; config accepted via valid/ready, applied only at a period wrap or while disabled.
module hr_dpwm_multiphase #(
    parameter int N_CH         = 2,
    parameter int Nde          = 64,
    parameter int DE_bits      = 6,
    parameter int Dc_length    = 13,
    parameter int Count_length = Dc_length - DE_bits,
    parameter int CW           = Count_length + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [CW-1:0]             cfg_period,
    input  logic [CW-1:0]             cfg_dt,
    input  logic [N_CH*Dc_length-1:0] cfg_duty,
    input  logic [N_CH*CW-1:0]        cfg_phase,
    output logic [N_CH-1:0]           DH_DPWM,
    output logic [N_CH-1:0]           DL_DPWM,
    output logic [N_CH*DE_bits-1:0]   DH_fine,
    output logic [N_CH-1:0]           DH_ext,
    output logic                      period_start
);

    // Fine code spans one clock of the delay line.
    localparam int FB = $clog2(Nde);

    logic [CW-1:0]             act_period, act_dt, pend_period, pend_dt;
    logic [N_CH*Dc_length-1:0] act_duty, pend_duty;
    logic [N_CH*CW-1:0]        act_phase, pend_phase;
    logic                      pend_vld;
    logic [CW-1:0]             cnt;

    logic [CW-1:0] p_eff;
    logic          wrap, xfer, accept;

    assign p_eff  = (act_period < CW'(2)) ? CW'(2) : act_period;
    assign wrap   = (cnt >= p_eff - 1'b1);
    assign xfer   = !en || wrap;
    assign accept = cfg_valid && cfg_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_period  <= '0;
            act_dt      <= '0;
            act_duty    <= '0;
            act_phase   <= '0;
            pend_period <= '0;
            pend_dt     <= '0;
            pend_duty   <= '0;
            pend_phase  <= '0;
            pend_vld    <= 1'b0;
            cfg_ready   <= 1'b0;
        end else begin
            // A config offered on the wrap cycle bypasses the pending stage.
            if (accept && xfer) begin
                act_period <= cfg_period;
                act_dt     <= cfg_dt;
                act_duty   <= cfg_duty;
                act_phase  <= cfg_phase;
            end else if (accept) begin
                pend_period <= cfg_period;
                pend_dt     <= cfg_dt;
                pend_duty   <= cfg_duty;
                pend_phase  <= cfg_phase;
            end else if (pend_vld && xfer) begin
                act_period <= pend_period;
                act_dt     <= pend_dt;
                act_duty   <= pend_duty;
                act_phase  <= pend_phase;
            end
            pend_vld  <= (accept || pend_vld) && !xfer;
            cfg_ready <= !((accept || pend_vld) && !xfer);
        end
    end

    logic [CW-1:0]      ph       [N_CH];
    logic [CW:0]        sum      [N_CH];
    logic [CW-1:0]      loc      [N_CH];
    logic [CW-1:0]      dc       [N_CH];
    logic [DE_bits-1:0] df       [N_CH];
    logic               ext      [N_CH];
    logic [CW+1:0]      hi_end   [N_CH];
    logic [CW+1:0]      dl_start [N_CH];

    logic [N_CH-1:0]         dh_n, dl_n, ext_n;
    logic [N_CH*DE_bits-1:0] fine_n;

    always_comb begin
        dh_n   = '0;
        dl_n   = '0;
        ext_n  = '0;
        fine_n = '0;
        for (int i = 0; i < N_CH; i++) begin
            ph[i] = act_phase[i*CW +: CW];
            if (ph[i] >= p_eff) ph[i] = '0;
            sum[i] = {1'b0, cnt} + {1'b0, ph[i]};
            loc[i] = (sum[i] >= {1'b0, p_eff}) ? CW'(sum[i] - {1'b0, p_eff}) : sum[i][CW-1:0];

            dc[i] = CW'(act_duty[i*Dc_length+DE_bits +: Dc_length-DE_bits]);
            if (dc[i] > p_eff) dc[i] = p_eff;
            df[i]  = DE_bits'(act_duty[i*Dc_length +: FB]);
            ext[i] = (df[i] != '0) && (dc[i] < p_eff);

            hi_end[i]   = {2'b00, dc[i]} + (CW+2)'(ext[i]);
            dl_start[i] = hi_end[i] + {2'b00, act_dt};

            // The dc > dt guard keeps a too-short pulse fully suppressed, fine extension included.
            if ((dc[i] > act_dt) && (loc[i] >= act_dt) && ({2'b00, loc[i]} < hi_end[i]))
                dh_n[i] = 1'b1;
            if (ext[i] && dh_n[i] && (loc[i] == dc[i])) begin
                ext_n[i]                    = 1'b1;
                fine_n[i*DE_bits +: DE_bits] = df[i];
            end
            if ((dl_start[i] < {2'b00, p_eff}) && ({2'b00, loc[i]} >= dl_start[i]))
                dl_n[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt          <= '0;
            DH_DPWM      <= '0;
            DL_DPWM      <= '0;
            DH_ext       <= '0;
            DH_fine      <= '0;
            period_start <= 1'b0;
        end else begin
            if (!en || wrap)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            DH_DPWM      <= en ? dh_n : '0;
            DL_DPWM      <= en ? dl_n : '0;
            DH_ext       <= en ? ext_n : '0;
            DH_fine      <= en ? fine_n : '0;
            period_start <= en && (cnt == '0);
        end
    end

endmodule

// File: tb/tb_hr_dpwm_multiphase.sv
// Directed bench for hr_dpwm_multiphase: per-config waveform table plus reset, mid-period config and enable sequences.
module tb_hr_dpwm_multiphase;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [7:0]  cfg_period;
    logic [7:0]  cfg_dt;
    logic [25:0] cfg_duty;
    logic [15:0] cfg_phase;
    logic [1:0]  DH_DPWM, DL_DPWM, DH_ext;
    logic [11:0] DH_fine;
    logic        period_start;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hr_dpwm_multiphase dut (
        .clk(clk), .rst(rst), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_period(cfg_period), .cfg_dt(cfg_dt), .cfg_duty(cfg_duty), .cfg_phase(cfg_phase),
        .DH_DPWM(DH_DPWM), .DL_DPWM(DL_DPWM), .DH_fine(DH_fine), .DH_ext(DH_ext),
        .period_start(period_start)
    );

    // Hand-computed region bounds per config; lo > hi means the region is empty, ext_loc -1 means no extension.
    typedef struct {
        int period, dt, duty, ph1;
        int peff, ph1e;
        int dh_lo, dh_hi, dl_lo, dl_hi, ext_loc, fine;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [2:0] exp_bits(input vec_t v, input int l);
        logic dh, dl, ex;
        dh = (l >= v.dh_lo) && (l <= v.dh_hi);
        dl = (l >= v.dl_lo) && (l <= v.dl_hi);
        ex = (l == v.ext_loc);
        return {ex, dl, dh};
    endfunction

    task automatic check_cycle(input string tag, input vec_t v, input int k);
        logic [2:0] e0, e1;
        logic [5:0] f0, f1;
        e0 = exp_bits(v, k);
        e1 = exp_bits(v, (k + v.ph1e) % v.peff);
        f0 = e0[2] ? 6'(v.fine) : 6'd0;
        f1 = e1[2] ? 6'(v.fine) : 6'd0;
        chk($sformatf("%s_DH_loc%0d", tag, k), 32'(DH_DPWM), 32'({e1[0], e0[0]}));
        chk($sformatf("%s_DL_loc%0d", tag, k), 32'(DL_DPWM), 32'({e1[1], e0[1]}));
        chk($sformatf("%s_EXT_loc%0d", tag, k), 32'(DH_ext), 32'({e1[2], e0[2]}));
        chk($sformatf("%s_FINE_loc%0d", tag, k), 32'(DH_fine), 32'({f1, f0}));
        chk($sformatf("%s_PS_loc%0d", tag, k), 32'(period_start), 32'(k == 0));
        chk($sformatf("%s_NOOVL_loc%0d", tag, k), 32'(DH_DPWM & DL_DPWM), 32'd0);
    endtask

    // Called at a negedge with en=0 so the config becomes active immediately.
    task automatic apply_cfg(input int p, input int dt, input int duty, input int ph1);
        logic [12:0] d;
        d = duty[12:0];
        chk("cfg_ready_idle", 32'(cfg_ready), 32'd1);
        cfg_period = p[7:0];
        cfg_dt     = dt[7:0];
        cfg_duty   = {d, d};
        cfg_phase  = {ph1[7:0], 8'd0};
        cfg_valid  = 1'b1;
        @(negedge clk);
        cfg_valid  = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        apply_cfg(v.period, v.dt, v.duty, v.ph1);
        en = 1'b1;
        for (int k = 0; k < 2 * v.peff; k++) begin
            @(negedge clk);
            check_cycle($sformatf("v%0d", idx), v, k % v.peff);
        end
        en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        vec_t nv;
        //            P  DT duty ph1 Pe ph1e dhlo dhhi dllo dlhi ext fine
        tbl[0] = '{20, 2,  512,  0, 20,  0,   2,   7,  10,  19, -1,  0};
        tbl[1] = '{20, 2,  549,  0, 20,  0,   2,   8,  11,  19,  8, 37};
        tbl[2] = '{20, 2,  512, 10, 20, 10,   2,   7,  10,  19, -1,  0};
        tbl[3] = '{20, 2,   64,  0, 20,  0,   1,   0,   3,  19, -1,  0};
        tbl[4] = '{20, 2, 1600,  0, 20,  0,   2,  19,   1,   0, -1,  0};
        tbl[5] = '{ 0, 0,   64,  0,  2,  0,   0,   0,   1,   1, -1,  0};
        tbl[6] = '{20, 3,  321, 25, 20,  0,   3,   5,   9,  19,  5,  1};
        tbl[7] = '{10, 1,  645,  0, 10,  0,   1,   9,   1,   0, -1,  0};
        tbl[8] = '{12, 2,  579,  5, 12,  5,   2,   9,   1,   0,  9,  3};
        tbl[9] = '{ 8, 3,  192,  7,  8,  7,   1,   0,   6,   7, -1,  0};

        rst = 1'b0; en = 1'b0; cfg_valid = 1'b0;
        cfg_period = '0; cfg_dt = '0; cfg_duty = '0; cfg_phase = '0;
        #1;
        chk("rst_DH", 32'(DH_DPWM), 32'd0);
        chk("rst_DL", 32'(DL_DPWM), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd0);
        chk("rst_ps", 32'(period_start), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(cfg_ready), 32'd1);

        for (int i = 0; i < 10; i++) run_vec(i, tbl[i]);

        // Config offered mid-period: held pending until the wrap, then the next period uses Dc=15.
        nv = '{20, 2, 960, 0, 20, 0, 2, 14, 17, 19, -1, 0};
        apply_cfg(20, 2, 512, 0);
        en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k < 20) check_cycle("mid_old", tbl[0], k);
            else        check_cycle("mid_new", nv, k - 20);
            if (k >= 4 && k <= 20)
                chk($sformatf("mid_ready_k%0d", k), 32'(cfg_ready), 32'(k < 5 || k >= 19));
            if (k == 4) begin
                cfg_duty  = {13'd960, 13'd960};
                cfg_valid = 1'b1;
            end
            if (k == 5) cfg_valid = 1'b0;
        end
        en = 1'b0;
        @(negedge clk);
        chk("en_off_DH", 32'(DH_DPWM), 32'd0);
        chk("en_off_DL", 32'(DL_DPWM), 32'd0);

        // Asynchronous reset while DH is high.
        apply_cfg(20, 2, 512, 0);
        en = 1'b1;
        for (int k = 0; k < 5; k++) @(negedge clk);
        chk("pre_rst_DH", 32'(DH_DPWM), 32'd3);
        #2;
        rst = 1'b0;
        en  = 1'b0;
        #1;
        chk("async_rst_DH", 32'(DH_DPWM), 32'd0);
        chk("async_rst_DL", 32'(DL_DPWM), 32'd0);
        chk("async_rst_ready", 32'(cfg_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_ready", 32'(cfg_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("idle_DH_%0d", k), 32'(DH_DPWM), 32'd0);
            chk($sformatf("idle_DL_%0d", k), 32'(DL_DPWM), 32'd0);
        end

        // Reset config: effective P=2, duty 0, dt 0 -> DL held high, DH never.
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("dflt_DH_%0d", k), 32'(DH_DPWM), 32'd0);
            chk($sformatf("dflt_DL_%0d", k), 32'(DL_DPWM), 32'd3);
            chk($sformatf("dflt_PS_%0d", k), 32'(period_start), 32'(k % 2 == 0));
        end
        en = 1'b0;
        @(negedge clk);
        chk("final_DL_off", 32'(DL_DPWM), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/hr_dpwm_multiphase.md
# hr_dpwm_multiphase

Multi-channel, phase-shifted, high-resolution DPWM output stage with a clocked timebase.

- Generates complementary high-side (DH) and low-side (DL) gate commands with dead-time for N_CH channels.
- Each channel has a coarse counter compare plus a DE_bits fine code that drives the external delay-element line.
- Configuration is double-buffered through a valid/ready handshake and takes effect only at a period boundary.
- Sits between the duty-cycle controller and the delay-line / gate-driver interface.

## Interface
- N_CH, 2: number of PWM channels
- Nde, 64: delay elements per clock cycle (2**DE_bits)
- DE_bits, 6: fine-resolution bits of the duty word
- Dc_length, 13: total duty word width
- Count_length, Dc_length-DE_bits: MSB index of coarse counters; coarse width CW = Count_length+1
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- en  in  1  run enable; 0 stops the timebase and forces outputs low
- cfg_valid  in  1  new configuration offered
- cfg_ready  out  1  configuration accepted when cfg_valid & cfg_ready
- cfg_period  in  CW  period P in clk cycles
- cfg_dt  in  CW  dead-time in clk cycles
- cfg_duty  in  N_CH*Dc_length  per-channel duty; channel i at [i*Dc_length +: Dc_length]
- cfg_phase  in  N_CH*CW  per-channel phase offset in clk cycles
- DH_DPWM  out  N_CH  high-side command
- DL_DPWM  out  N_CH  low-side command
- DH_fine  out  N_CH*DE_bits  fine code for the DH falling edge; valid while DH_ext[i]=1
- DH_ext  out  N_CH  DH_DPWM[i] is in its fine-extension cycle
- period_start  out  1  one-cycle pulse at each period start

## Operation
- Timebase: counter cnt runs 0..P-1, then wraps to 0.
  - Effective P is max(cfg_period, 2).
  - Active config is held in shadow registers.
- Local count per channel: loc_i = cnt + ph_i.
  - Subtract P if the sum is ≥ P.
  - ph_i ≥ P is treated as 0.
  - Sum is computed at CW+1 bits.
- Duty split: Dc_i = duty[Dc_length-1:DE_bits] (coarse), Df_i = duty[DE_bits-1:0] (fine).
  - Dc_i is clipped to P.
  - ext_i = (Df_i != 0) & (Dc_i < P).
- DH high region: DT ≤ loc_i < Dc_i + ext_i.
  - DH_ext[i]=1 on loc_i = Dc_i when ext_i.
  - DH_fine[i] = Df_i while DH_ext[i]=1, else 0.
- DL high region: Dc_i + ext_i + DT ≤ loc_i < P.
- Empty regions stay low for the whole period, with no glitch.
  - DH empty if Dc_i ≤ DT.
  - DL empty if Dc_i + ext_i + DT ≥ P.
- DH and DL are never both 1 in the same cycle (invariant, for any config).
- Config handshake:
  - cfg_ready=1 when no config is pending.
  - On accept: latch into the pending register; cfg_ready → 0.
  - On the cycle cnt wraps P-1 → 0 (or while en=0): pending → active; cfg_ready → 1 the next cycle.
  - A config is never applied mid-period.
- Enable:
  - en=0: cnt held at 0; all outputs 0; a pending config is transferred immediately.
  - en 0→1: cnt starts at 0 on the next edge.
  - period_start fires with cnt=0 of the first period.
- Reset (rst=0, asynchronous):
  - All outputs 0, cfg_ready 0.
  - cnt 0; active and pending config cleared (P=0 → effective 2, duty 0, dt 0, phase 0).
  - cfg_ready = 1 in the first cycle after rst release.

## Timing
- Outputs are registered. DH_DPWM, DL_DPWM, DH_ext, DH_fine and period_start at edge t+1 reflect cnt/active config at edge t. Latency is 1 clk.
- Config accepted during period k takes effect in period k+1.
  - First affected output cycle: 1 clk after the wrap.
  - If accepted on the wrap cycle itself, it is applied at that wrap.
- en deassert: outputs low 1 clk later.
- rst assert: outputs low immediately, without waiting for a clk edge.

## Test plan
- Reset in mid-period with DH=1:
  - Stimulus: P=20, DT=2, ch0 duty=(8<<6).
  - Required: DH/DL drop at once; cfg_ready=1 one cycle after release; outputs stay 0 until en.
- Basic waveform:
  - Stimulus: P=20, DT=2, ch0 duty=(8<<6)|0, phase 0.
  - Required: DH high for loc 2..7 (6 cycles); DL high for loc 10..19 (10 cycles); DH_ext never set.
- Fine extension:
  - Stimulus: duty=(8<<6)|37.
  - Required: DH high loc 2..8; DH_ext=1 and DH_fine=37 only at loc 8; DL high loc 11..19.
- Phase shift:
  - Stimulus: N_CH=2, phase1=10, same duty on both channels.
  - Required: ch1 waveform equals ch0 delayed 10 cycles; DH_DPWM[0]&DL_DPWM[0] and DH_DPWM[1]&DL_DPWM[1] always 0.
- Mid-period config:
  - Stimulus: offer duty=(15<<6) at cnt=5.
  - Required: handshake completes; cfg_ready stays 0 until the wrap; the current period keeps Dc=8; the next period has DH loc 2..14.
- Boundary configs:
  - duty=(1<<6), DT=2 → DH never high.
  - duty=(25<<6), P=20 → Dc clipped to 20; DH loc 2..19; DL never high.
  - P=0 → effective period 2.
